piso_serializer: RTL

- Parallel-in serial-out transmitter: the sending end of the 4-bit serial link whose receiving end is the SIPO register.
- Accepts a parallel word through a valid/ready handshake, then drives one bit per CLK on OUT. Bit order and timing let a SIPO clocked on the same CLK rebuild the word.
- Supports back-to-back words with no idle gap, and marks the last bit of each word on LAST.

---
 rtl/piso_serializer.sv | 93 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter for a WIDTH-bit serial link.
// A word is accepted on LOAD && READY and streamed one bit per clock on OUT. The
// first bit appears the cycle after acceptance. LAST flags the final bit, and a
// new word may be accepted on that final bit so that consecutive words leave no gap.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             READY,
  output logic             OUT,
  output logic             OUT_VALID,
  output logic             LAST
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    count_q;
  logic             out_q;
  logic             out_valid_q;
  logic             last_q;

  // Incoming word rearranged into transmit order: the bit to send first sits at
  // the MSB. The shift register therefore always shifts left, whatever the bit order.
  logic [WIDTH-1:0] word_ord;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign word_ord[gi] = D[gi];
      end else begin : g_lsb
        assign word_ord[gi] = D[WIDTH-1-gi];
      end
    end
  endgenerate

  logic accept;

  // Ready while idle, or on the final bit of a word so the next word follows
  // without a gap. Held low while reset is asserted.
  assign READY  = RST && ((state_q == IDLE) || (state_q == SHIFT && count_q == '0));
  assign accept = LOAD && READY;

  // Transmit FSM. The serial outputs are registered in the same process.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else if (accept) begin
      // Present the first bit now. Keep the remaining bits in order, MSB-aligned.
      state_q     <= SHIFT;
      shreg_q     <= {word_ord[WIDTH-2:0], 1'b0};
      count_q     <= CNT_INIT;
      out_q       <= word_ord[WIDTH-1];
      out_valid_q <= 1'b1;
      last_q      <= 1'b0;
    end else if (state_q == SHIFT && count_q != '0) begin
      shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
      count_q     <= count_q - CNT_ONE;
      out_q       <= shreg_q[WIDTH-1];
      out_valid_q <= 1'b1;
      last_q      <= (count_q == CNT_ONE);
    end else begin
      // Idle with no request, or the final bit with no follow-on word.
      state_q     <= IDLE;
      count_q     <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign LAST      = last_q;

endmodule
